// File: rtl/kmeans_seq_ctrl.sv
// Parametrised k-means sequencer: centroid load, point streaming through the classify pipe,
// divider/convergence walk, iteration control, centroid write-back and completion interrupt.
module kmeans_seq_ctrl #(
    parameter int CENT_NUM      = 8,
    parameter int CENT_W        = 3,
    parameter int ADDR_W        = 9,
    parameter int REG_W         = 4,
    parameter int CENT_REG_BASE = 2,
    parameter int PIPE_DEPTH    = 3,
    parameter int ITER_W        = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                go,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   first_addr,
    input  logic [ADDR_W-1:0]   last_addr,
    input  logic [ITER_W-1:0]   max_iter,
    input  logic                irq_ack,
    input  logic                cnvg_valid,
    input  logic                has_converged,
    output logic                busy,
    output logic [REG_W-1:0]    reg_num,
    output logic                reg_write,
    output logic                irq,
    output logic [1:0]          status,
    output logic [ITER_W-1:0]   iter_cnt,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic                ram_cs_n,
    output logic                ram_oe_n,
    output logic                ram_in_en,
    output logic [CENT_NUM-1:0] cent_en,
    output logic [CENT_W-1:0]   cent_idx,
    output logic                first_iter,
    output logic                acc_en,
    output logic                acc_clr_n,
    output logic                div_en,
    output logic                cnvg_en
);
    localparam int CNT_MAX = (CENT_NUM > PIPE_DEPTH) ? CENT_NUM : PIPE_DEPTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CLASSIFY, S_DRAIN, S_CALC, S_CHECK, S_WB, S_IRQ
    } state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [ADDR_W-1:0]   first_reg, first_next;
    logic [ADDR_W-1:0]   last_reg, last_next;
    logic [ITER_W-1:0]   iter_reg, iter_next, iter_inc;
    logic [1:0]          status_reg, status_next;
    logic                irq_reg, irq_next;
    logic                first_iter_reg, first_iter_next;
    logic                flush;
    logic                walk;

    logic                busy_next, reg_write_next, ram_cs_n_next, ram_in_en_next;
    logic                acc_clr_n_next, div_en_next, cnvg_en_next;
    logic [REG_W-1:0]    reg_num_next;
    logic [ADDR_W-1:0]   ram_addr_next;
    logic [CENT_NUM-1:0] cent_en_next;
    logic [CENT_W-1:0]   cent_idx_next;
    logic [PIPE_DEPTH-1:0] vld_pipe;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            addr_reg       <= '0;
            first_reg      <= '0;
            last_reg       <= '0;
            iter_reg       <= '0;
            status_reg     <= '0;
            irq_reg        <= 1'b0;
            first_iter_reg <= 1'b1;
            busy           <= 1'b0;
            reg_num        <= '0;
            reg_write      <= 1'b0;
            ram_addr       <= '0;
            ram_cs_n       <= 1'b1;
            ram_oe_n       <= 1'b1;
            ram_in_en      <= 1'b0;
            cent_en        <= '0;
            cent_idx       <= '0;
            acc_clr_n      <= 1'b1;
            div_en         <= 1'b0;
            cnvg_en        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            addr_reg       <= addr_next;
            first_reg      <= first_next;
            last_reg       <= last_next;
            iter_reg       <= iter_next;
            status_reg     <= status_next;
            irq_reg        <= irq_next;
            first_iter_reg <= first_iter_next;
            busy           <= busy_next;
            reg_num        <= reg_num_next;
            reg_write      <= reg_write_next;
            ram_addr       <= ram_addr_next;
            ram_cs_n       <= ram_cs_n_next;
            ram_oe_n       <= ram_cs_n_next;
            ram_in_en      <= ram_in_en_next;
            cent_en        <= cent_en_next;
            cent_idx       <= cent_idx_next;
            acc_clr_n      <= acc_clr_n_next;
            div_en         <= div_en_next;
            cnvg_en        <= cnvg_en_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        addr_next       = addr_reg;
        first_next      = first_reg;
        last_next       = last_reg;
        iter_next       = iter_reg;
        status_next     = status_reg;
        irq_next        = irq_reg;
        first_iter_next = first_iter_reg;
        flush           = 1'b0;
        iter_inc        = (&iter_reg) ? iter_reg : iter_reg + 1'b1;
        case (state_reg)
            S_IDLE: begin
                // a pending abort interrupt is the only irq that can be live in IDLE
                if (irq_ack) irq_next = 1'b0;
                if (go) begin
                    if (last_addr < first_addr) begin
                        status_next = 2'd3;
                        irq_next    = 1'b1;
                        state_next  = S_IRQ;
                    end else begin
                        status_next     = 2'd0;
                        iter_next       = '0;
                        irq_next        = 1'b0;
                        first_next      = first_addr;
                        last_next       = last_addr;
                        cnt_next        = '0;
                        first_iter_next = 1'b1;
                        state_next      = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (cnt_reg == CNT_W'(CENT_NUM - 1)) begin
                    addr_next  = first_reg;
                    state_next = S_CLASSIFY;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_CLASSIFY: begin
                if (addr_reg == last_reg) begin
                    cnt_next   = '0;
                    state_next = S_DRAIN;
                end else begin
                    addr_next = addr_reg + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt_reg == CNT_W'(PIPE_DEPTH - 1)) begin
                    first_iter_next = 1'b0;
                    state_next      = S_CALC;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_CALC: begin
                cnt_next   = '0;
                state_next = S_CHECK;
            end
            S_CHECK: begin
                // cnt == CENT_NUM marks the end of the walk; only then is cnvg_valid honoured
                if (cnt_reg != CNT_W'(CENT_NUM)) begin
                    cnt_next = cnt_reg + 1'b1;
                end else if (cnvg_valid) begin
                    iter_next = iter_inc;
                    cnt_next  = '0;
                    if (has_converged) begin
                        status_next = 2'd1;
                        state_next  = S_WB;
                    end else if (max_iter != '0 &&
                                 ({1'b0, iter_reg} + 1'b1) == {1'b0, max_iter}) begin
                        status_next = 2'd2;
                        state_next  = S_WB;
                    end else begin
                        addr_next  = first_reg;
                        state_next = S_CLASSIFY;
                    end
                end
            end
            S_WB: begin
                if (cnt_reg == CNT_W'(CENT_NUM - 1)) begin
                    irq_next   = 1'b1;
                    state_next = S_IRQ;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_IRQ: begin
                if (irq_ack) begin
                    irq_next   = 1'b0;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (abort && state_reg != S_IDLE) begin
            state_next      = S_IDLE;
            cnt_next        = '0;
            addr_next       = '0;
            iter_next       = '0;
            status_next     = 2'd3;
            irq_next        = 1'b1;
            first_iter_next = 1'b1;
            flush           = 1'b1;
        end
    end

    // Outputs are decoded from the next state so they are registered without a cycle of lag.
    always_comb begin
        walk           = (state_next == S_LOAD) ||
                         (state_next == S_CHECK && cnt_next < CNT_W'(CENT_NUM));
        busy_next      = !(state_next == S_IDLE || state_next == S_IRQ);
        reg_num_next   = (state_next == S_LOAD || state_next == S_WB) ?
                         REG_W'(CENT_REG_BASE) + REG_W'(cnt_next) : '0;
        reg_write_next = (state_next == S_WB);
        ram_in_en_next = (state_next == S_CLASSIFY);
        ram_cs_n_next  = !ram_in_en_next;
        ram_addr_next  = ram_in_en_next ? addr_next : '0;
        cent_en_next   = walk ? (CENT_NUM'(1) << cnt_next) : '0;
        cent_idx_next  = walk ? CENT_W'(cnt_next) : '0;
        acc_clr_n_next = !(state_next == S_CLASSIFY && state_reg != S_CLASSIFY);
        div_en_next    = (state_next == S_CALC) || (state_next == S_CHECK);
        cnvg_en_next   = (state_next == S_CHECK);
    end

    generate
        for (genvar gi = 0; gi < PIPE_DEPTH; gi++) begin : g_vld
            logic stage_in;
            if (gi == 0) begin : g_head
                assign stage_in = ram_in_en;
            end else begin : g_body
                assign stage_in = vld_pipe[gi-1];
            end
            always_ff @(posedge clk) begin
                if (!rst_n || flush) vld_pipe[gi] <= 1'b0;
                else                 vld_pipe[gi] <= stage_in;
            end
        end
    endgenerate

    assign acc_en     = vld_pipe[PIPE_DEPTH-1];
    assign irq        = irq_reg;
    assign status     = status_reg;
    assign iter_cnt   = iter_reg;
    assign first_iter = first_iter_reg;
endmodule

// File: tb/tb_kmeans_seq_ctrl.sv
// Directed bench for kmeans_seq_ctrl: a job table run through a cycle monitor, plus hand-written
// range-error, abort and mid-CHECK reset sequences (the latter on a CENT_NUM=4, PIPE_DEPTH=2 copy).
module tb_kmeans_seq_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rst_nb, go, sel, abort, irq_ack, cnvg_valid, has_converged;
    logic [8:0] first_addr, last_addr;
    logic [7:0] max_iter;

    logic busy_a, reg_write_a, irq_a, ram_cs_n_a, ram_oe_n_a, ram_in_en_a;
    logic first_iter_a, acc_en_a, acc_clr_n_a, div_en_a, cnvg_en_a;
    logic [3:0] reg_num_a;
    logic [1:0] status_a;
    logic [7:0] iter_cnt_a, cent_en_a;
    logic [8:0] ram_addr_a;
    logic [2:0] cent_idx_a;

    logic busy_b, reg_write_b, irq_b, ram_cs_n_b, ram_oe_n_b, ram_in_en_b;
    logic first_iter_b, acc_en_b, acc_clr_n_b, div_en_b, cnvg_en_b;
    logic [3:0] reg_num_b, cent_en_b;
    logic [1:0] status_b, cent_idx_b;
    logic [7:0] iter_cnt_b;
    logic [8:0] ram_addr_b;

    kmeans_seq_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .go(go & ~sel), .abort(abort),
        .first_addr(first_addr), .last_addr(last_addr), .max_iter(max_iter),
        .irq_ack(irq_ack), .cnvg_valid(cnvg_valid), .has_converged(has_converged),
        .busy(busy_a), .reg_num(reg_num_a), .reg_write(reg_write_a), .irq(irq_a),
        .status(status_a), .iter_cnt(iter_cnt_a), .ram_addr(ram_addr_a),
        .ram_cs_n(ram_cs_n_a), .ram_oe_n(ram_oe_n_a), .ram_in_en(ram_in_en_a),
        .cent_en(cent_en_a), .cent_idx(cent_idx_a), .first_iter(first_iter_a),
        .acc_en(acc_en_a), .acc_clr_n(acc_clr_n_a), .div_en(div_en_a), .cnvg_en(cnvg_en_a)
    );

    kmeans_seq_ctrl #(.CENT_NUM(4), .CENT_W(2), .PIPE_DEPTH(2)) dut_b (
        .clk(clk), .rst_n(rst_nb), .go(go & sel), .abort(abort),
        .first_addr(first_addr), .last_addr(last_addr), .max_iter(max_iter),
        .irq_ack(irq_ack), .cnvg_valid(cnvg_valid), .has_converged(has_converged),
        .busy(busy_b), .reg_num(reg_num_b), .reg_write(reg_write_b), .irq(irq_b),
        .status(status_b), .iter_cnt(iter_cnt_b), .ram_addr(ram_addr_b),
        .ram_cs_n(ram_cs_n_b), .ram_oe_n(ram_oe_n_b), .ram_in_en(ram_in_en_b),
        .cent_en(cent_en_b), .cent_idx(cent_idx_b), .first_iter(first_iter_b),
        .acc_en(acc_en_b), .acc_clr_n(acc_clr_n_b), .div_en(div_en_b), .cnvg_en(cnvg_en_b)
    );

    // monitor view of whichever instance sel points at
    wire       m_busy = sel ? busy_b : busy_a;
    wire [3:0] m_reg_num = sel ? reg_num_b : reg_num_a;
    wire       m_reg_write = sel ? reg_write_b : reg_write_a;
    wire       m_irq = sel ? irq_b : irq_a;
    wire [1:0] m_status = sel ? status_b : status_a;
    wire [7:0] m_iter = sel ? iter_cnt_b : iter_cnt_a;
    wire [8:0] m_ram_addr = sel ? ram_addr_b : ram_addr_a;
    wire       m_cs_n = sel ? ram_cs_n_b : ram_cs_n_a;
    wire       m_oe_n = sel ? ram_oe_n_b : ram_oe_n_a;
    wire       m_in_en = sel ? ram_in_en_b : ram_in_en_a;
    wire [7:0] m_cent_en = sel ? {4'd0, cent_en_b} : cent_en_a;
    wire [2:0] m_cent_idx = sel ? {1'b0, cent_idx_b} : cent_idx_a;
    wire       m_first_iter = sel ? first_iter_b : first_iter_a;
    wire       m_acc_en = sel ? acc_en_b : acc_en_a;
    wire       m_clr_n = sel ? acc_clr_n_b : acc_clr_n_a;
    wire       m_div_en = sel ? div_en_b : div_en_a;
    wire       m_cnvg_en = sel ? cnvg_en_b : cnvg_en_a;
    wire [44:0] m_vec = {m_busy, m_reg_num, m_reg_write, m_irq, m_status, m_iter, m_ram_addr,
                         m_cs_n, m_oe_n, m_in_en, m_cent_en, m_cent_idx, m_first_iter,
                         m_acc_en, m_clr_n, m_div_en, m_cnvg_en};

    localparam logic [44:0] RST_VEC = {1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 8'd0, 9'd0, 1'b1, 1'b1,
                                       1'b0, 8'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic [44:0] ABT_VEC = {1'b0, 4'd0, 1'b0, 1'b1, 2'd3, 8'd0, 9'd0, 1'b1, 1'b1,
                                       1'b0, 8'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    typedef struct {
        bit sel;
        int first, last, maxi, conv_on;
        int exp_status, exp_iter, exp_pts, exp_passes, exp_cent, exp_lat;
    } job_t;

    localparam int NJ = 6;
    job_t jobs [NJ];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input int j);
        int load_n = 0, wb_n = 0, ram_n = 0, acc_n = 0, passes = 0;
        int seq_err = 0, addr_err = 0, t_issue = -1, t_acc = -1, exp_addr = 0, hold_err = 0;
        bit done = 0;
        sel = jobs[j].sel;
        first_addr = 9'(jobs[j].first);
        last_addr  = 9'(jobs[j].last);
        max_iter   = 8'(jobs[j].maxi);
        go = 1'b1;
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            tick();
            go = 1'b0;
            cnvg_valid = 1'b0;
            has_converged = 1'b0;
            if (m_cent_en != 0 && !m_cnvg_en) begin
                load_n++;
                if (!m_first_iter || m_reg_num != 4'(2 + m_cent_idx)) seq_err++;
            end
            if (!m_clr_n) begin
                passes++;
                exp_addr = jobs[j].first;
            end
            if (!m_cs_n) begin
                ram_n++;
                if (t_issue < 0) t_issue = cyc;
                if (m_ram_addr != 9'(exp_addr) || m_oe_n || !m_in_en) addr_err++;
                exp_addr++;
            end
            if (m_acc_en) begin
                acc_n++;
                if (t_acc < 0) t_acc = cyc;
            end
            if (m_reg_write) begin
                if (m_reg_num != 4'(2 + wb_n)) seq_err++;
                wb_n++;
            end
            if (m_div_en && !m_cnvg_en && m_first_iter) seq_err++;
            if (m_cnvg_en && m_cent_en == 0) begin
                cnvg_valid = 1'b1;
                has_converged = (passes == jobs[j].conv_on);
            end
            if (m_irq) done = 1;
        end
        check("irq_raised", done, 1);
        check("load_cycles", load_n, jobs[j].exp_cent);
        check("wb_writes", wb_n, jobs[j].exp_cent);
        check("reg_seq", seq_err, 0);
        check("ram_cycles", ram_n, jobs[j].exp_pts);
        check("ram_addr_seq", addr_err, 0);
        check("acc_cycles", acc_n, jobs[j].exp_pts);
        check("acc_latency", t_acc - t_issue, jobs[j].exp_lat);
        check("passes", passes, jobs[j].exp_passes);
        check("status", m_status, jobs[j].exp_status);
        check("iter_cnt", m_iter, jobs[j].exp_iter);
        check("busy_in_irq", m_busy, 0);
        repeat (3) begin
            tick();
            if (!m_irq) hold_err++;
        end
        check("irq_hold", hold_err, 0);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("irq_clear", m_irq, 0);
        check("status_after_ack", m_status, jobs[j].exp_status);
        $display("[TB] job %0d dut=%0d first=%0d last=%0d status=%0d iter=%0d pts=%0d passes=%0d",
                 j, sel, jobs[j].first, jobs[j].last, m_status, m_iter, ram_n, passes);
    endtask

    initial begin
        int cnt;
        //           sel first last maxi conv status iter pts passes cent lat
        jobs[0] = '{0,  0,   9,   0,   1,   1,    1,   10,  1,    8,   3};
        jobs[1] = '{0,  0,   4,   3,   0,   2,    3,   15,  3,    8,   3};
        jobs[2] = '{0,  7,   7,   0,   1,   1,    1,   1,   1,    8,   3};
        jobs[3] = '{0,  20,  22,  0,   2,   1,    2,   6,   2,    8,   3};
        jobs[4] = '{0,  3,   5,   1,   0,   2,    1,   3,   1,    8,   3};
        jobs[5] = '{1,  10,  13,  0,   1,   1,    1,   4,   1,    4,   2};

        rst_n = 1'b0; rst_nb = 1'b0; go = 1'b0; sel = 1'b0; abort = 1'b0; irq_ack = 1'b0;
        cnvg_valid = 1'b0; has_converged = 1'b0;
        first_addr = '0; last_addr = '0; max_iter = '0;
        repeat (3) tick();
        check("reset_a", m_vec, RST_VEC);
        sel = 1'b1;
        #1 check("reset_b", m_vec, RST_VEC);
        sel = 1'b0;
        rst_n = 1'b1; rst_nb = 1'b1;
        tick();

        for (int j = 0; j < NJ - 1; j++) run_job(j);

        // inverted range: straight to IRQ, no RAM access
        first_addr = 9'd5; last_addr = 9'd4; max_iter = 8'd0; go = 1'b1;
        tick();
        go = 1'b0;
        check("range_irq", m_irq, 1);
        check("range_status", m_status, 3);
        cnt = 0;
        repeat (4) begin
            if (!m_cs_n || m_busy) cnt++;
            tick();
        end
        check("range_no_ram", cnt, 0);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("range_irq_clear", m_irq, 0);
        $display("[TB] range error first=5 last=4 status=%0d", m_status);

        // abort while point 4 of 10 is being issued
        first_addr = 9'd0; last_addr = 9'd9; go = 1'b1;
        cnt = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            go = 1'b0;
            if (!m_cs_n && m_ram_addr == 9'd4) begin
                cnt = 1;
                break;
            end
        end
        check("abort_reach_pt4", cnt, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_outputs", m_vec, ABT_VEC);
        cnt = 0;
        repeat (3) begin
            tick();
            if (!m_irq || m_busy) cnt++;
        end
        check("abort_irq_hold", cnt, 0);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("abort_irq_clear", m_irq, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle_ignored", {m_busy, m_irq, m_status}, {1'b0, 1'b0, 2'd3});
        $display("[TB] abort at point 4 status=%0d", m_status);

        // small instance: reset while waiting in CHECK, then a clean restart
        sel = 1'b1;
        first_addr = 9'd0; last_addr = 9'd3; go = 1'b1;
        cnt = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            go = 1'b0;
            if (m_cnvg_en && m_cent_en == 0) begin
                cnt = 1;
                break;
            end
        end
        check("b_reach_check", cnt, 1);
        rst_nb = 1'b0;
        tick();
        check("b_reset_mid_check", m_vec, RST_VEC);
        rst_nb = 1'b1;
        $display("[TB] reset mid-CHECK on CENT_NUM=4 instance");
        tick();
        run_job(NJ - 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
